// File: rtl/winograd_acc_pkg.sv
// Shared types for the Winograd accumulator stage: FSM state encoding and
// the stage-1 (resolved carry-save) width helper.
package winograd_acc_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // Sum of two IN_SIZE operands needs one extra bit.
   function automatic int s1_width(input int in_size);
      return in_size + 1;
   endfunction

endpackage

// File: rtl/winograd_acc_adder.sv
// Stage-2 accumulator adder: ACC_SIZE add with carry out.
// WINOGRAD_ACC_SAT_EN defined: a carry clamps the sum to all-ones; otherwise wraps.
module winograd_acc_adder #(
   parameter int ACC_SIZE = 32
) (
   input  logic [ACC_SIZE-1:0] i_a,
   input  logic [ACC_SIZE-1:0] i_b,
   output logic [ACC_SIZE-1:0] o_sum,
   output logic                o_carry
);

   logic [ACC_SIZE:0] w_full;

   assign w_full  = {1'b0, i_a} + {1'b0, i_b};
   assign o_carry = w_full[ACC_SIZE];

`ifdef WINOGRAD_ACC_SAT_EN
   // Once clamped, later adds of any value carry again (or add zero), so the
   // accumulator stays at all-ones for the rest of the group without extra state.
   assign o_sum = w_full[ACC_SIZE] ? '1 : w_full[ACC_SIZE-1:0];
`else
   assign o_sum = w_full[ACC_SIZE-1:0];
`endif

endmodule

// File: rtl/winograd_acc.sv
// Winograd output accumulator: resolves the carry-save pair, accumulates over a
// run-time group length, emits one result per group. Optional macro: WINOGRAD_ACC_SAT_EN.
//
//   state | meaning
//   ACCUM | accepting beats (in_ready_o=1), counting towards the group length
//   DRAIN | last beat in stage 1, being folded into the accumulator
//   HOLD  | result presented (out_valid_o=1) until the downstream handshake
module winograd_acc
   import winograd_acc_pkg::*;
#(
   parameter int IN_SIZE  = 24,
   parameter int ACC_SIZE = 32,
   parameter int LEN_W    = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [IN_SIZE-1:0]  in_data_i [0:1],
   input  logic [LEN_W-1:0]    len_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [ACC_SIZE-1:0] out_data_o,
   output logic                out_ovf_o
);

   localparam int S1_W = s1_width(IN_SIZE);

   if (ACC_SIZE < S1_W) begin : g_bad_acc_size
      $error("winograd_acc: ACC_SIZE must be >= IN_SIZE+1");
   end

   state_e               r_state;
   state_e               w_state_nxt;
   logic                 w_in_ready;
   logic                 w_out_valid;

   logic [S1_W-1:0]      r_s1;
   logic                 r_s1_valid;
   logic                 r_first;
   logic                 r_ovf;
   logic [ACC_SIZE-1:0]  r_acc;
   logic [LEN_W-1:0]     r_cnt;
   logic [LEN_W-1:0]     r_len;

   logic                 w_accept;
   logic                 w_handshake;
   logic                 w_cnt_hit;
   logic [LEN_W-1:0]     w_len_eff;
   logic [LEN_W-1:0]     w_len_cur;
   logic [LEN_W-1:0]     w_cnt_inc;
   logic [ACC_SIZE-1:0]  w_add_a;
   logic [ACC_SIZE-1:0]  w_s1_ext;
   logic [ACC_SIZE-1:0]  w_sum;
   logic                 w_carry;

   assign w_accept    = in_valid_i && (r_state == ACCUM);
   assign w_handshake = (r_state == HOLD) && out_ready_i;

   // The first beat of a group uses len_i directly; later beats use the latched copy.
   assign w_len_eff = (len_i == '0) ? LEN_W'(1) : len_i;
   assign w_len_cur = (r_cnt == '0) ? w_len_eff : r_len;
   assign w_cnt_inc = r_cnt + LEN_W'(1);
   assign w_cnt_hit = (w_cnt_inc == w_len_cur);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         ACCUM: begin
            w_in_ready = 1'b1;
            if (in_valid_i && w_cnt_hit) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            w_state_nxt = HOLD;
         end
         HOLD: begin
            w_out_valid = 1'b1;
            if (out_ready_i) begin
               w_state_nxt = ACCUM;
            end
         end
         default: begin
            w_state_nxt = ACCUM;
         end
      endcase
   end

   assign in_ready_o  = w_in_ready;
   assign out_valid_o = w_out_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
         r_len <= '0;
      end else if (w_handshake) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= w_cnt_inc;
         if (r_cnt == '0) begin
            r_len <= w_len_eff;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1       <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1 <= S1_W'(in_data_i[0]) + S1_W'(in_data_i[1]);
         end
      end
   end

   // Feeding zero as the first operand on the group's first beat loads s1
   // through the same adder, and can never produce a carry.
   assign w_s1_ext = ACC_SIZE'(r_s1);
   assign w_add_a  = r_first ? '0 : r_acc;

   winograd_acc_adder #(
      .ACC_SIZE (ACC_SIZE)
   ) u_adder (
      .i_a     (w_add_a),
      .i_b     (w_s1_ext),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_first <= 1'b1;
      end else if (w_handshake) begin
         r_ovf   <= 1'b0;
         r_first <= 1'b1;
      end else if (r_s1_valid) begin
         r_acc   <= w_sum;
         r_ovf   <= (r_first ? 1'b0 : r_ovf) | w_carry;
         r_first <= 1'b0;
      end
   end

   assign out_data_o = r_acc;
   assign out_ovf_o  = r_ovf;

endmodule
